// File: rtl/instr_encoder.sv
// instr_encoder: packs decoded RV32I fields into R/I/S/B/U/J words and streams them
// to instruction memory at auto-incrementing addresses. Define INSTR_ENC_RANGE_CHECK_EN for immediate range errors.
module instr_encoder #(
  parameter int                ADDR_W    = 10,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              restart,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [6:0]        req_opcode,
  input  logic [4:0]        req_rd,
  input  logic [4:0]        req_rs1,
  input  logic [4:0]        req_rs2,
  input  logic [2:0]        req_funct3,
  input  logic [6:0]        req_funct7,
  input  logic [31:0]       req_imm,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ready,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              err,
  output logic [1:0]        err_code
);

  localparam logic [6:0]  OP_R     = 7'b0110011;
  localparam logic [6:0]  OP_I_ALU = 7'b0010011;
  localparam logic [6:0]  OP_LOAD  = 7'b0000011;
  localparam logic [6:0]  OP_JALR  = 7'b1100111;
  localparam logic [6:0]  OP_S     = 7'b0100011;
  localparam logic [6:0]  OP_B     = 7'b1100011;
  localparam logic [6:0]  OP_LUI   = 7'b0110111;
  localparam logic [6:0]  OP_AUIPC = 7'b0010111;
  localparam logic [6:0]  OP_JAL   = 7'b1101111;
  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [ADDR_W:0] CAPACITY = {1'b1, {ADDR_W{1'b0}}};

  logic        accept;
  logic [31:0] enc_word;
  logic        op_bad;
  logic        imm_bad;

  // Handshake: a request transfers on a rising edge where req_valid && req_ready;
  // the output word transfers where mem_we && mem_ready. Both sides are strict
  // valid/ready: the producer holds its payload stable until the transfer edge.
  assign full      = (count == CAPACITY);
  assign req_ready = !restart && !full && (!mem_we || mem_ready);
  assign accept    = req_valid && req_ready;

  always_comb begin
    enc_word = NOP;
    op_bad   = 1'b0;
    case (req_opcode)
      OP_R:
        enc_word = {req_funct7, req_rs2, req_rs1, req_funct3, req_rd, req_opcode};
      OP_I_ALU, OP_LOAD, OP_JALR:
        enc_word = {req_imm[11:0], req_rs1, req_funct3, req_rd, req_opcode};
      OP_S:
        enc_word = {req_imm[11:5], req_rs2, req_rs1, req_funct3, req_imm[4:0], req_opcode};
      OP_B:
        enc_word = {req_imm[12], req_imm[10:5], req_rs2, req_rs1, req_funct3,
                    req_imm[4:1], req_imm[11], req_opcode};
      OP_LUI, OP_AUIPC:
        enc_word = {req_imm[31:12], req_rd, req_opcode};
      OP_JAL:
        enc_word = {req_imm[20], req_imm[10:1], req_imm[11], req_imm[19:12], req_rd, req_opcode};
      default: begin
        enc_word = NOP;
        op_bad   = 1'b1;
      end
    endcase
  end

`ifdef INSTR_ENC_RANGE_CHECK_EN
  // A value fits an N-bit signed field when all bits from N-1 upward agree.
  logic fits_12;
  logic fits_13;
  logic fits_21;
  assign fits_12 = (&req_imm[31:11]) || !(|req_imm[31:11]);
  assign fits_13 = (&req_imm[31:12]) || !(|req_imm[31:12]);
  assign fits_21 = (&req_imm[31:20]) || !(|req_imm[31:20]);

  always_comb begin
    imm_bad = 1'b0;
    case (req_opcode)
      OP_I_ALU, OP_LOAD, OP_JALR, OP_S: imm_bad = !fits_12;
      OP_B:                             imm_bad = !fits_13 || req_imm[0];
      OP_JAL:                           imm_bad = !fits_21 || req_imm[0];
      OP_LUI, OP_AUIPC:                 imm_bad = |req_imm[11:0];
      default:                          imm_bad = 1'b0;
    endcase
  end
`else
  assign imm_bad = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_we    <= 1'b0;
      mem_addr  <= BASE_ADDR;
      mem_wdata <= '0;
      count     <= '0;
      err       <= 1'b0;
      err_code  <= 2'b00;
    end else if (restart) begin
      // A write completing this cycle has already been taken by memory.
      mem_we   <= 1'b0;
      mem_addr <= BASE_ADDR;
      count    <= '0;
      err      <= 1'b0;
      err_code <= 2'b00;
    end else if (accept) begin
      mem_we    <= 1'b1;
      mem_wdata <= enc_word;
      mem_addr  <= BASE_ADDR + count[ADDR_W-1:0];
      count     <= count + (ADDR_W+1)'(1);
      if (!err && (op_bad || imm_bad)) begin
        err      <= 1'b1;
        err_code <= op_bad ? 2'b01 : 2'b10;
      end
    end else if (mem_ready) begin
      mem_we <= 1'b0;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed test-plan steps plus a randomized
// phase, all scored against a behavioural model of the encoder kept in this file.
module tb_instr_encoder;

  localparam int         AW    = 2;
  localparam int         DEPTH = 4;
  localparam logic [1:0] BASE  = 2'd1;
`ifdef INSTR_ENC_RANGE_CHECK_EN
  localparam bit RANGE_EN = 1'b1;
`else
  localparam bit RANGE_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          restart = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [6:0]    req_opcode = '0;
  logic [4:0]    req_rd = '0;
  logic [4:0]    req_rs1 = '0;
  logic [4:0]    req_rs2 = '0;
  logic [2:0]    req_funct3 = '0;
  logic [6:0]    req_funct7 = '0;
  logic [31:0]   req_imm = '0;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          mem_ready = 1'b1;
  logic [AW:0]   count;
  logic          full;
  logic          err;
  logic [1:0]    err_code;

  instr_encoder #(.ADDR_W(AW), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst_n(rst_n), .restart(restart),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_opcode(req_opcode), .req_rd(req_rd), .req_rs1(req_rs1), .req_rs2(req_rs2),
    .req_funct3(req_funct3), .req_funct7(req_funct7), .req_imm(req_imm),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
    .count(count), .full(full), .err(err), .err_code(err_code)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard / model state ----------------
  logic [31:0] exp_q[$];
  int          exp_addr_q[$];
  int          wr_log[$];
  int          m_count;
  bit          m_err;
  int          m_code;
  int          checks = 0;
  int          failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit op_known(input logic [6:0] op);
    return op inside {7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F};
  endfunction

  // Reference encoder built from the field placement rules with shifts and masks.
  function automatic logic [31:0] ref_encode(input logic [6:0] op, input int unsigned rd,
      input int unsigned rs1, input int unsigned rs2, input int unsigned f3,
      input int unsigned f7, input logic [31:0] imm);
    int unsigned u;
    int unsigned o;
    u = imm;
    o = 32'(op);
    case (op)
      7'h33: return (f7 << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | o;
      7'h13, 7'h03, 7'h67:
        return ((u & 32'hFFF) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | o;
      7'h23:
        return (((u >> 5) & 32'h7F) << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12)
               | ((u & 32'h1F) << 7) | o;
      7'h63:
        return (((u >> 12) & 1) << 31) | (((u >> 5) & 32'h3F) << 25) | (rs2 << 20)
               | (rs1 << 15) | (f3 << 12) | (((u >> 1) & 32'hF) << 8)
               | (((u >> 11) & 1) << 7) | o;
      7'h37, 7'h17: return (u & 32'hFFFFF000) | (rd << 7) | o;
      7'h6F:
        return (((u >> 20) & 1) << 31) | (((u >> 1) & 32'h3FF) << 21)
               | (((u >> 11) & 1) << 20) | (((u >> 12) & 32'hFF) << 12) | (rd << 7) | o;
      default: return 32'h0000_0013;
    endcase
  endfunction

  // Error code a request would raise: 0 none, 1 opcode, 2 immediate range.
  function automatic int ref_code(input logic [6:0] op, input logic [31:0] imm);
    int s;
    s = int'(imm);
    if (!op_known(op)) return 1;
    if (!RANGE_EN) return 0;
    case (op)
      7'h13, 7'h03, 7'h67, 7'h23: return (s < -2048 || s > 2047) ? 2 : 0;
      7'h63: return (s < -4096 || s > 4094 || (s % 2) != 0) ? 2 : 0;
      7'h6F: return (s < -1048576 || s > 1048574 || (s % 2) != 0) ? 2 : 0;
      7'h37, 7'h17: return ((imm & 32'hFFF) != 0) ? 2 : 0;
      default: return 0;
    endcase
  endfunction

  function automatic void m_reset();
    exp_q.delete();
    exp_addr_q.delete();
    m_count = 0;
    m_err   = 1'b0;
    m_code  = 0;
  endfunction

  // One clock: check all outputs at the negedge, advance the model, step past the posedge.
  task automatic cycle();
    bit pend;
    bit exp_ready;
    int code;
    @(negedge clk);
    pend      = exp_q.size() != 0;
    exp_ready = !restart && (m_count < DEPTH) && (!pend || mem_ready);
    chk("req_ready", 64'(req_ready), 64'(exp_ready));
    chk("mem_we", 64'(mem_we), 64'(pend));
    if (pend) begin
      chk("mem_addr", 64'(mem_addr), 64'(exp_addr_q[0]));
      chk("mem_wdata", 64'(mem_wdata), 64'(exp_q[0]));
    end
    chk("count", 64'(count), 64'(m_count));
    chk("full", 64'(full), 64'(m_count == DEPTH));
    chk("err", 64'(err), 64'(m_err));
    chk("err_code", 64'(err_code), 64'(m_code));
    if (pend && mem_ready) begin
      void'(exp_q.pop_front());
      wr_log.push_back(exp_addr_q.pop_front());
    end
    if (restart) begin
      exp_q.delete();
      exp_addr_q.delete();
      m_count = 0;
      m_err   = 1'b0;
      m_code  = 0;
    end else if (req_valid && exp_ready) begin
      exp_q.push_back(ref_encode(req_opcode, req_rd, req_rs1, req_rs2, req_funct3,
                                 req_funct7, req_imm));
      exp_addr_q.push_back((int'(BASE) + m_count) % DEPTH);
      m_count++;
      code = ref_code(req_opcode, req_imm);
      if (!m_err && code != 0) begin
        m_err  = 1'b1;
        m_code = code;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_fields(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
      input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] imm);
    req_opcode = op;
    req_rd     = rd;
    req_rs1    = rs1;
    req_rs2    = rs2;
    req_funct3 = f3;
    req_funct7 = f7;
    req_imm    = imm;
  endtask

  task automatic send(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
      input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] imm);
    set_fields(op, rd, rs1, rs2, f3, f7, imm);
    req_valid = 1'b1;
    cycle();
    req_valid = 1'b0;
  endtask

  task automatic rand_fields();
    logic [6:0] ops[10];
    int idx;
    ops = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h00};
    idx = $urandom_range(0, 9);
    if (idx == 9) ops[9] = 7'($urandom_range(0, 127));
    req_opcode = ops[idx];
    req_rd     = 5'($urandom);
    req_rs1    = 5'($urandom);
    req_rs2    = 5'($urandom);
    req_funct3 = 3'($urandom);
    req_funct7 = 7'($urandom);
    case ($urandom_range(0, 2))
      0:       req_imm = $urandom;
      1:       req_imm = 32'(int'($urandom_range(0, 10000)) - 5000);
      default: req_imm = $urandom & 32'hFFFFF000;
    endcase
  endtask

  task automatic pulse_restart();
    restart = 1'b1;
    cycle();
    restart = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_mem_we"}, 64'(mem_we), 64'(0));
    chk({tag, "_mem_addr"}, 64'(mem_addr), 64'(BASE));
    chk({tag, "_mem_wdata"}, 64'(mem_wdata), 64'(0));
    chk({tag, "_count"}, 64'(count), 64'(0));
    chk({tag, "_full"}, 64'(full), 64'(0));
    chk({tag, "_err"}, 64'(err), 64'(0));
    chk({tag, "_err_code"}, 64'(err_code), 64'(0));
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = 1'b0;
    restart   = 1'b0;
    mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_values("rst");
    rst_n = 1'b1;
    m_reset();
    @(posedge clk);
    #1;
    chk("rst_ready_after", 64'(req_ready), 64'(1));
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    do_reset();

    // R-type lands at BASE one cycle after accept
    send(7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
    chk("r_word", 64'(mem_wdata), 64'(32'h002081B3));
    chk("r_addr", 64'(mem_addr), 64'(BASE));
    chk("r_we", 64'(mem_we), 64'(1));
    pulse_restart();

    // beq then jal at consecutive addresses
    send(7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, -32'sd8);
    chk("b_word", 64'(mem_wdata), 64'(32'hFE208CE3));
    send(7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048);
    chk("j_word", 64'(mem_wdata), 64'(32'h001000EF));
    chk("j_addr", 64'(mem_addr), 64'(BASE + 2'd1));
    chk("bj_count", 64'(count), 64'(2));
    cycle();

    // lui under a three-cycle memory stall with a waiting request
    mem_ready = 1'b0;
    send(7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000);
    set_fields(7'h33, 5'd7, 5'd8, 5'd9, 3'd1, 7'd0, 32'd0);
    req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("u_word", 64'(mem_wdata), 64'(32'h123452B7));
      chk("u_addr", 64'(mem_addr), 64'(2'd3));
      chk("u_stall_ready", 64'(req_ready), 64'(0));
      cycle();
    end
    req_valid = 1'b0;
    mem_ready = 1'b1;
    cycle();
    chk("u_done_we", 64'(mem_we), 64'(0));
    pulse_restart();

    // immediate range then unsupported opcode
    send(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048);
    chk("range_word", 64'(mem_wdata), 64'(32'h80000093));
    chk("range_err", 64'(err), 64'(RANGE_EN));
    chk("range_code", 64'(err_code), RANGE_EN ? 64'(2) : 64'(0));
    send(7'h7F, 5'd1, 5'd2, 5'd3, 3'd0, 7'd0, 32'd0);
    chk("badop_word", 64'(mem_wdata), 64'(32'h00000013));
    chk("badop_err", 64'(err), 64'(1));
    chk("badop_code", 64'(err_code), RANGE_EN ? 64'(2) : 64'(1));
    cycle();
    pulse_restart();
    chk("restart_err", 64'(err), 64'(0));

    // fill the memory: addresses wrap 1,2,3,0
    wr_log.delete();
    for (int i = 0; i < DEPTH; i++) begin
      rand_fields();
      send(req_opcode, req_rd, req_rs1, req_rs2, req_funct3, req_funct7, req_imm);
    end
    req_valid = 1'b1;
    cycle();
    chk("full_flag", 64'(full), 64'(1));
    chk("full_ready", 64'(req_ready), 64'(0));
    chk("full_count", 64'(count), 64'(DEPTH));
    req_valid = 1'b0;
    chk("full_nwrites", 64'(wr_log.size()), 64'(DEPTH));
    for (int i = 0; i < wr_log.size() && i < DEPTH; i++)
      chk("full_wr_addr", 64'(wr_log[i]), 64'((1 + i) % DEPTH));
    pulse_restart();
    chk("restart_count", 64'(count), 64'(0));
    send(7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
    chk("restart_addr", 64'(mem_addr), 64'(BASE));
    cycle();

    // randomized traffic with stalls and occasional restarts
    for (int i = 0; i < 400; i++) begin
      mem_ready = ($urandom_range(0, 3) != 0);
      restart   = (m_count == DEPTH) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 15) == 0);
      req_valid = ($urandom_range(0, 3) != 0);
      rand_fields();
      cycle();
    end
    restart   = 1'b0;
    req_valid = 1'b0;
    mem_ready = 1'b1;
    cycle();

    // asynchronous reset while a word is pending
    pulse_restart();
    mem_ready = 1'b0;
    send(7'h6F, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd16);
    chk("ar_we_before", 64'(mem_we), 64'(1));
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values("async");
    m_reset();
    @(negedge clk);
    rst_n     = 1'b1;
    mem_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("ar_ready_after", 64'(req_ready), 64'(1));
    send(7'h33, 5'd4, 5'd5, 5'd6, 3'd2, 7'd32, 32'd0);
    cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
